// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
//   I2C target with a 16 x 8 register file that stands in for an MPU6050-style
//   sensor. The bus master addresses the block, sets a 4-bit register pointer
//   and then reads or writes bursts with pointer auto-increment. Local logic
//   loads "sensor" values through a separate write port. Register 0xF always
//   reads WHOAMI.
// Ports
//   MCLK, RESET          system clock, synchronous active-high reset
//   SCL_IN, SDA_IN       raw asynchronous bus pin levels
//   SDA_OUT              open-drain control: 1 = release, 0 = pull low
//   LOC_WE/ADR/DATA      local register write port (one MCLK strobe)
//   REG_WR/ADR/DATA      one-MCLK notification of a bus register write
//   BUSY                 high while this target is engaged in a transaction
module i2c_target_regfile #(
  parameter logic [6:0] DEVICE = 7'h68,
  parameter logic [7:0] WHOAMI = 8'h68
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  input  logic       LOC_WE,
  input  logic [3:0] LOC_ADR,
  input  logic [7:0] LOC_DATA,
  output logic       REG_WR,
  output logic [3:0] REG_ADR,
  output logic [7:0] REG_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_P, S_WDATA, S_ACK_W, S_RDATA, S_MACK
  } state_t;

  // Register 0xF has no storage of its own: it always returns WHOAMI.
  function automatic logic [7:0] rd_byte(input logic [3:0] idx, input logic [7:0] val);
    logic [7:0] r;
    if (idx == 4'hF) begin
      r = WHOAMI;
    end else begin
      r = val;
    end
    return r;
  endfunction

  logic       scl_meta_q, scl_sync_q, scl_dly_q;
  logic       sda_meta_q, sda_sync_q, sda_dly_q;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       sda_out_q, sda_out_d;
  logic       busy_q, busy_d;
  logic       reg_wr_q, reg_wr_d;
  logic [3:0] reg_adr_q, reg_adr_d;
  logic [7:0] reg_data_q, reg_data_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];

  logic       scl_rise, scl_fall, scl_high, start_det, stop_det, byte_done;
  logic [7:0] shift_in, rd_cur, rd_nxt;
  logic [3:0] ptr_inc;

  // Bus pin synchroniser plus one delay stage for edge detection; idle level is high.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      scl_meta_q <= 1'b1; scl_sync_q <= 1'b1; scl_dly_q <= 1'b1;
      sda_meta_q <= 1'b1; sda_sync_q <= 1'b1; sda_dly_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL_IN; scl_sync_q <= scl_meta_q; scl_dly_q <= scl_sync_q;
      sda_meta_q <= SDA_IN; sda_sync_q <= sda_meta_q; sda_dly_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_dly_q;
  assign scl_fall  = ~scl_sync_q & scl_dly_q;
  assign scl_high  = scl_sync_q & scl_dly_q;
  assign start_det = scl_high & ~sda_sync_q & sda_dly_q;
  assign stop_det  = scl_high & sda_sync_q & ~sda_dly_q;
  // The 8th rising edge has already shifted the last bit; act on the following fall.
  assign byte_done = scl_fall & (cnt_q == 4'd8);
  assign shift_in  = {sh_q[6:0], sda_sync_q};
  assign ptr_inc   = ptr_q + 4'd1;
  assign rd_cur    = rd_byte(ptr_q, regs_q[ptr_q]);
  assign rd_nxt    = rd_byte(ptr_inc, regs_q[ptr_inc]);

  // Next-state logic for the bus protocol FSM and the register file.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    sda_out_d  = sda_out_q;
    busy_d     = busy_q;
    reg_wr_d   = 1'b0;
    reg_adr_d  = reg_adr_q;
    reg_data_d = reg_data_q;
    regs_d     = regs_q;

    // Local write first so a same-cycle bus write to the same index overrides it.
    if (LOC_WE && (LOC_ADR != 4'hF)) begin
      regs_d[LOC_ADR] = LOC_DATA;
    end else begin
      regs_d[4'hF] = regs_q[4'hF];
    end

    if (start_det) begin
      state_d   = S_ADDR;
      cnt_d     = 4'd0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_out_d = 1'b1;
          busy_d    = 1'b0;
        end
        S_ADDR: begin
          if (scl_rise) begin
            sh_d  = shift_in;
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            if (sh_q[7:1] == DEVICE) begin
              state_d   = S_ACK_A;
              rw_d      = sh_q[0];
              sda_out_d = 1'b0;
              busy_d    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_ACK_A: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d   = S_RDATA;
              sh_d      = rd_cur;
              sda_out_d = rd_cur[7];
            end else begin
              state_d   = S_PTR;
              sda_out_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_PTR: begin
          if (scl_rise) begin
            sh_d  = shift_in;
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d   = S_ACK_P;
            ptr_d     = sh_q[3:0];
            sda_out_d = 1'b0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            sh_d  = shift_in;
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d    = S_ACK_W;
            sda_out_d  = 1'b0;
            reg_wr_d   = 1'b1;
            reg_adr_d  = ptr_q;
            reg_data_d = sh_q;
            ptr_d      = ptr_inc;
            if (ptr_q != 4'hF) begin
              regs_d[ptr_q] = sh_q;
            end else begin
              regs_d[4'hF] = regs_q[4'hF];
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_ACK_P, S_ACK_W: begin
          if (scl_fall) begin
            state_d   = S_WDATA;
            cnt_d     = 4'd0;
            sda_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d   = S_MACK;
            sda_out_d = 1'b1;
          end else if (scl_fall) begin
            sh_d      = {sh_q[6:0], 1'b0};
            sda_out_d = sh_q[6];
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            mack_d = sda_sync_q;
          end else if (scl_fall) begin
            cnt_d = 4'd0;
            if (!mack_q) begin
              state_d   = S_RDATA;
              ptr_d     = ptr_inc;
              sh_d      = rd_nxt;
              sda_out_d = rd_nxt[7];
            end else begin
              state_d   = S_IDLE;
              sda_out_d = 1'b1;
              busy_d    = 1'b0;
            end
          end else begin
            mack_d = mack_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          sda_out_d = 1'b1;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State, register file and registered outputs.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'h00;
      ptr_q      <= 4'h0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      sda_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_adr_q  <= 4'h0;
      reg_data_q <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      sda_out_q  <= sda_out_d;
      busy_q     <= busy_d;
      reg_wr_q   <= reg_wr_d;
      reg_adr_q  <= reg_adr_d;
      reg_data_q <= reg_data_d;
      regs_q     <= regs_d;
    end
  end

  assign SDA_OUT  = sda_out_q;
  assign REG_WR   = reg_wr_q;
  assign REG_ADR  = reg_adr_q;
  assign REG_DATA = reg_data_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile
//   Directed bench: a bit-banged I2C master drives the target through writes,
//   repeated-START reads, a foreign address, an aborted byte and a reset in the
//   middle of a read, comparing against hand-computed values.
module tb_i2c_target_regfile;

  localparam int Q = 8;  // MCLK cycles per quarter SCL period

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       SDA_OUT;
  logic       LOC_WE = 1'b0;
  logic [3:0] LOC_ADR = 4'h0;
  logic [7:0] LOC_DATA = 8'h00;
  logic       REG_WR;
  logic [3:0] REG_ADR;
  logic [7:0] REG_DATA;
  logic       BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int sda_low_cnt = 0;
  logic [3:0] wr_adr_log [$];
  logic [7:0] wr_data_log [$];

  assign sda_line = sda_m & SDA_OUT;

  i2c_target_regfile dut (
    .MCLK(MCLK), .RESET(RESET), .SCL_IN(scl_m), .SDA_IN(sda_line), .SDA_OUT(SDA_OUT),
    .LOC_WE(LOC_WE), .LOC_ADR(LOC_ADR), .LOC_DATA(LOC_DATA),
    .REG_WR(REG_WR), .REG_ADR(REG_ADR), .REG_DATA(REG_DATA), .BUSY(BUSY)
  );

  always #5 MCLK = ~MCLK;

  // Log bus-write pulses and accumulate BUSY / SDA-pull activity.
  always @(negedge MCLK) begin
    if (REG_WR) begin
      wr_adr_log.push_back(REG_ADR);
      wr_data_log.push_back(REG_DATA);
    end
    if (BUSY) busy_cnt++;
    if (!SDA_OUT) sda_low_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic loc_write(input logic [3:0] idx, input logic [7:0] d);
    LOC_WE = 1'b1; LOC_ADR = idx; LOC_DATA = d;
    tick(1);
    LOC_WE = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    check_eq(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic       b;
    logic [7:0] t;
    t = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      t[i] = b;
    end
    write_bit(ack);
    d = t;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [7:0] d);
    i2c_start();
    write_byte(8'hD0, 1'b0, "rr_addr_w_ack");
    write_byte({4'h0, idx}, 1'b0, "rr_ptr_ack");
    i2c_rstart();
    write_byte(8'hD1, 1'b0, "rr_addr_r_ack");
    read_byte(d, 1'b1);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] d;
    logic       b;
    int         b0, s0, w0;

    // Reset state
    tick(3);
    check_eq("rst_sda_out", {31'd0, SDA_OUT}, 32'd1);
    check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rst_reg_wr", {31'd0, REG_WR}, 32'd0);
    check_eq("rst_reg_adr", {28'd0, REG_ADR}, 32'd0);
    check_eq("rst_reg_data", {24'd0, REG_DATA}, 32'd0);
    RESET = 1'b0;
    tick(4);

    // Burst write 0x68/W, ptr 2, A5, 3C
    i2c_start();
    write_byte(8'hD0, 1'b0, "w_addr_ack");
    check_eq("w_busy", {31'd0, BUSY}, 32'd1);
    write_byte(8'h02, 1'b0, "w_ptr_ack");
    write_byte(8'hA5, 1'b0, "w_d0_ack");
    write_byte(8'h3C, 1'b0, "w_d1_ack");
    i2c_stop();
    tick(4);
    check_eq("w_busy_after_stop", {31'd0, BUSY}, 32'd0);
    check_eq("w_sda_after_stop", {31'd0, SDA_OUT}, 32'd1);
    check_eq("w_log_size", wr_adr_log.size(), 32'd2);
    if (wr_adr_log.size() >= 2) begin
      check_eq("w_log0_adr", {28'd0, wr_adr_log[0]}, 32'h2);
      check_eq("w_log0_data", {24'd0, wr_data_log[0]}, 32'hA5);
      check_eq("w_log1_adr", {28'd0, wr_adr_log[1]}, 32'h3);
      check_eq("w_log1_data", {24'd0, wr_data_log[1]}, 32'h3C);
    end else begin
      check_eq("w_log_entries", wr_adr_log.size(), 32'd2);
    end

    // Pointer left at 4: read without setting it
    loc_write(4'h4, 8'h5A);
    i2c_start();
    write_byte(8'hD1, 1'b0, "p4_addr_ack");
    read_byte(d, 1'b1);
    i2c_stop();
    check_eq("ptr_after_burst", {24'd0, d}, 32'h5A);

    // Read back bus-written regs 2, 3
    i2c_start();
    write_byte(8'hD0, 1'b0, "rb_addr_ack");
    write_byte(8'h02, 1'b0, "rb_ptr_ack");
    i2c_rstart();
    write_byte(8'hD1, 1'b0, "rb_addr_r_ack");
    read_byte(d, 1'b0);
    check_eq("rb_reg2", {24'd0, d}, 32'hA5);
    read_byte(d, 1'b1);
    check_eq("rb_reg3", {24'd0, d}, 32'h3C);
    i2c_stop();

    // Repeated-START read from 0xE across WHOAMI and the wrap to 0
    loc_write(4'hE, 8'h77);
    loc_write(4'h0, 8'h99);
    i2c_start();
    write_byte(8'hD0, 1'b0, "rs_addr_ack");
    write_byte(8'h0E, 1'b0, "rs_ptr_ack");
    i2c_rstart();
    write_byte(8'hD1, 1'b0, "rs_addr_r_ack");
    check_eq("rs_busy", {31'd0, BUSY}, 32'd1);
    read_byte(d, 1'b0);
    check_eq("rs_reg_e", {24'd0, d}, 32'h77);
    read_byte(d, 1'b0);
    check_eq("rs_whoami", {24'd0, d}, 32'h68);
    read_byte(d, 1'b1);
    check_eq("rs_reg_0", {24'd0, d}, 32'h99);
    tick(4);
    check_eq("rs_sda_after_nack", {31'd0, SDA_OUT}, 32'd1);
    i2c_stop();

    // Bus write to 0xF is dropped but still reported; pointer wraps to 0
    w0 = wr_adr_log.size();
    i2c_start();
    write_byte(8'hD0, 1'b0, "wf_addr_ack");
    write_byte(8'h0F, 1'b0, "wf_ptr_ack");
    write_byte(8'h12, 1'b0, "wf_d0_ack");
    write_byte(8'h34, 1'b0, "wf_d1_ack");
    i2c_stop();
    check_eq("wf_log_size", wr_adr_log.size() - w0, 32'd2);
    if (wr_adr_log.size() >= w0 + 2) begin
      check_eq("wf_log0_adr", {28'd0, wr_adr_log[w0]}, 32'hF);
      check_eq("wf_log1_adr", {28'd0, wr_adr_log[w0+1]}, 32'h0);
    end else begin
      check_eq("wf_log_entries", wr_adr_log.size() - w0, 32'd2);
    end
    loc_write(4'hF, 8'h55);
    read_reg(4'hF, d);
    check_eq("wf_reg_f", {24'd0, d}, 32'h68);
    read_reg(4'h0, d);
    check_eq("wf_reg_0_wrapped", {24'd0, d}, 32'h34);

    // Foreign address 0x69: no ACK, no BUSY, no writes
    b0 = busy_cnt; s0 = sda_low_cnt; w0 = wr_adr_log.size();
    i2c_start();
    write_byte(8'hD2, 1'b1, "fa_nack");
    write_byte(8'h55, 1'b1, "fa_byte1");
    write_byte(8'h66, 1'b1, "fa_byte2");
    i2c_stop();
    check_eq("fa_busy_cycles", busy_cnt - b0, 32'd0);
    check_eq("fa_sda_low_cycles", sda_low_cnt - s0, 32'd0);
    check_eq("fa_no_reg_wr", wr_adr_log.size() - w0, 32'd0);

    // Read byte is captured at load time; a mid-byte local write shows next time
    loc_write(4'h5, 8'h11);
    i2c_start();
    write_byte(8'hD0, 1'b0, "lw_addr_ack");
    write_byte(8'h05, 1'b0, "lw_ptr_ack");
    i2c_rstart();
    write_byte(8'hD1, 1'b0, "lw_addr_r_ack");
    fork
      read_byte(d, 1'b1);
      begin
        tick(40);
        loc_write(4'h5, 8'h22);
      end
    join
    i2c_stop();
    check_eq("lw_captured", {24'd0, d}, 32'h11);
    read_reg(4'h5, d);
    check_eq("lw_updated", {24'd0, d}, 32'h22);

    // STOP after 4 data bits abandons the byte
    w0 = wr_adr_log.size();
    i2c_start();
    write_byte(8'hD0, 1'b0, "ab_addr_ack");
    write_byte(8'h07, 1'b0, "ab_ptr_ack");
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    tick(4);
    check_eq("ab_no_reg_wr", wr_adr_log.size() - w0, 32'd0);
    check_eq("ab_sda", {31'd0, SDA_OUT}, 32'd1);
    check_eq("ab_busy", {31'd0, BUSY}, 32'd0);
    i2c_start();
    write_byte(8'hD0, 1'b0, "ab2_addr_ack");
    write_byte(8'h07, 1'b0, "ab2_ptr_ack");
    write_byte(8'h4B, 1'b0, "ab2_d_ack");
    i2c_stop();
    check_eq("ab2_log_size", wr_adr_log.size() - w0, 32'd1);
    read_reg(4'h7, d);
    check_eq("ab2_reg7", {24'd0, d}, 32'h4B);

    // Reset in the middle of a read while the target pulls SDA low
    i2c_start();
    write_byte(8'hD0, 1'b0, "mr_addr_ack");
    write_byte(8'h02, 1'b0, "mr_ptr_ack");
    i2c_rstart();
    write_byte(8'hD1, 1'b0, "mr_addr_r_ack");
    read_bit(b);
    check_eq("mr_bit7", {31'd0, b}, 32'd1);
    check_eq("mr_sda_low", {31'd0, SDA_OUT}, 32'd0);
    RESET = 1'b1;
    tick(1);
    check_eq("mr_sda_released", {31'd0, SDA_OUT}, 32'd1);
    check_eq("mr_busy", {31'd0, BUSY}, 32'd0);
    check_eq("mr_reg_adr", {28'd0, REG_ADR}, 32'd0);
    check_eq("mr_reg_data", {24'd0, REG_DATA}, 32'd0);
    scl_m = 1'b1; tick(2);
    sda_m = 1'b1; tick(4);
    RESET = 1'b0;
    tick(4);
    loc_write(4'h0, 8'hC3);
    i2c_start();
    write_byte(8'hD1, 1'b0, "mr2_addr_ack");
    read_byte(d, 1'b1);
    i2c_stop();
    check_eq("mr_ptr_zero", {24'd0, d}, 32'hC3);
    read_reg(4'h3, d);
    check_eq("mr_reg3_cleared", {24'd0, d}, 32'h00);
    read_reg(4'hF, d);
    check_eq("mr_whoami", {24'd0, d}, 32'h68);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
